// File: rtl/i_cache_2way.sv
// i_cache_2way
// 2-way set-associative, write-back, write-allocate cache with one-word blocks.
// Each set has true LRU. At most one miss is outstanding at a time. A miss is
// filled through the memory's 1-cycle-latency read port. A dirty victim is
// written back on the independent write port in the same cycle.
module i_cache_2way #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_WIDTH   = 12,
    parameter int INDEX_WIDTH = 6
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADD_WIDTH-1:0]  cpu_add,
    input  logic [DATA_WIDTH-1:0] cpu_data_in,
    input  logic                  cpu_ren,
    input  logic                  cpu_wen,
    output logic                  hit_miss,
    output logic [DATA_WIDTH-1:0] cpu_data_out,
    output logic [DATA_WIDTH-1:0] m_data_out,
    output logic [ADD_WIDTH-1:0]  m_wr_address,
    output logic                  m_wen,
    output logic [ADD_WIDTH-1:0]  m_rd_address,
    output logic                  m_ren,
    input  logic [DATA_WIDTH-1:0] m_data_in
);

    localparam int NSETS     = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = ADD_WIDTH - INDEX_WIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] FILL = 2'd2;

    logic [DATA_WIDTH-1:0] mem1 [NSETS];
    logic [DATA_WIDTH-1:0] mem2 [NSETS];
    logic [TAG_WIDTH-1:0]  tag1 [NSETS];
    logic [TAG_WIDTH-1:0]  tag2 [NSETS];
    logic [NSETS-1:0]      valid1, valid2;
    logic [NSETS-1:0]      dirty1, dirty2;
    logic [NSETS-1:0]      lru1, lru2;

    logic [1:0]            state;
    logic [ADD_WIDTH-1:0]  lat_add;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_wen;
    logic                  lat_way2;

    logic                  request;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic                  hit1, hit2;
    logic                  victim_way2;
    logic                  victim_dirty;
    logic [TAG_WIDTH-1:0]  victim_tag;
    logic [DATA_WIDTH-1:0] victim_data;
    logic [INDEX_WIDTH-1:0] fill_index;
    logic [TAG_WIDTH-1:0]  fill_tag;
    logic [DATA_WIDTH-1:0] fill_data;

    // Decode the CPU request and compare its tag against both ways of the set
    always_comb begin
        request   = cpu_ren | cpu_wen;
        req_index = cpu_add[INDEX_WIDTH-1:0];
        req_tag   = cpu_add[ADD_WIDTH-1:INDEX_WIDTH];
        hit1      = valid1[req_index] && (tag1[req_index] == req_tag);
        hit2      = valid2[req_index] && (tag2[req_index] == req_tag);
    end

    // Victim choice: an empty way first (way1 before way2), otherwise the way whose lru bit is clear
    always_comb begin
        if (!valid1[req_index])
            victim_way2 = 1'b0;
        else if (!valid2[req_index])
            victim_way2 = 1'b1;
        else if (!lru1[req_index])
            victim_way2 = 1'b0;
        else if (!lru2[req_index])
            victim_way2 = 1'b1;
        else
            victim_way2 = 1'b0;
        victim_dirty = victim_way2 ? (valid2[req_index] && dirty2[req_index])
                                   : (valid1[req_index] && dirty1[req_index]);
        victim_tag   = victim_way2 ? tag2[req_index] : tag1[req_index];
        victim_data  = victim_way2 ? mem2[req_index] : mem1[req_index];
    end

    // Fill word: a latched write replaces the memory word outright
    always_comb begin
        fill_index = lat_add[INDEX_WIDTH-1:0];
        fill_tag   = lat_add[ADD_WIDTH-1:INDEX_WIDTH];
        fill_data  = lat_wen ? lat_data : m_data_in;
    end

    // Data and tag storage: written on write hits and on fills, never cleared by reset
    always_ff @(posedge clock) begin
        if (reset_n) begin
            if (state == IDLE && request && cpu_wen) begin
                if (hit1)
                    mem1[req_index] <= cpu_data_in;
                else if (hit2)
                    mem2[req_index] <= cpu_data_in;
            end
            if (state == FILL) begin
                if (lat_way2) begin
                    mem2[fill_index] <= fill_data;
                    tag2[fill_index] <= fill_tag;
                end else begin
                    mem1[fill_index] <= fill_data;
                    tag1[fill_index] <= fill_tag;
                end
            end
        end
    end

    // Control FSM with valid/dirty/lru bookkeeping and all registered outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state        <= IDLE;
            valid1       <= '0;
            valid2       <= '0;
            dirty1       <= '0;
            dirty2       <= '0;
            lru1         <= '0;
            lru2         <= '0;
            hit_miss     <= 1'b0;
            cpu_data_out <= '0;
            m_data_out   <= '0;
            m_wr_address <= '0;
            m_wen        <= 1'b0;
            m_rd_address <= '0;
            m_ren        <= 1'b0;
            lat_add      <= '0;
            lat_data     <= '0;
            lat_wen      <= 1'b0;
            lat_way2     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!request) begin
                        hit_miss <= 1'b0;
                    end else if (hit1 || hit2) begin
                        hit_miss <= 1'b1;
                        if (!cpu_wen)
                            cpu_data_out <= hit1 ? mem1[req_index] : mem2[req_index];
                        if (hit1) begin
                            if (cpu_wen)
                                dirty1[req_index] <= 1'b1;
                            lru1[req_index] <= 1'b1;
                            lru2[req_index] <= 1'b0;
                        end else begin
                            if (cpu_wen)
                                dirty2[req_index] <= 1'b1;
                            lru1[req_index] <= 1'b0;
                            lru2[req_index] <= 1'b1;
                        end
                    end else begin
                        hit_miss     <= 1'b0;
                        m_ren        <= 1'b1;
                        m_rd_address <= cpu_add;
                        lat_add      <= cpu_add;
                        lat_data     <= cpu_data_in;
                        lat_wen      <= cpu_wen;
                        lat_way2     <= victim_way2;
                        if (victim_dirty) begin
                            m_wen        <= 1'b1;
                            m_wr_address <= {victim_tag, req_index};
                            m_data_out   <= victim_data;
                        end
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    m_ren <= 1'b0;
                    m_wen <= 1'b0;
                    state <= FILL;
                end
                FILL: begin
                    if (lat_way2) begin
                        valid2[fill_index] <= 1'b1;
                        dirty2[fill_index] <= lat_wen;
                        lru2[fill_index]   <= 1'b1;
                        lru1[fill_index]   <= 1'b0;
                    end else begin
                        valid1[fill_index] <= 1'b1;
                        dirty1[fill_index] <= lat_wen;
                        lru1[fill_index]   <= 1'b1;
                        lru2[fill_index]   <= 1'b0;
                    end
                    if (!lat_wen)
                        cpu_data_out <= m_data_in;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i_cache_2way.sv
// tb_i_cache_2way
// Runs directed and random accesses against i_cache_2way. A word memory is
// attached to the cache. Each cache set is modelled as an MRU-ordered list of
// up to two blocks. A golden memory image is kept alongside that model.
module tb_i_cache_2way;

    logic        clock;
    logic        reset_n;
    logic [11:0] cpu_add;
    logic [31:0] cpu_data_in;
    logic        cpu_ren;
    logic        cpu_wen;
    logic        hit_miss;
    logic [31:0] cpu_data_out;
    logic [31:0] m_data_out;
    logic [11:0] m_wr_address;
    logic        m_wen;
    logic [11:0] m_rd_address;
    logic        m_ren;
    logic [31:0] m_data_in;

    int tests_run    = 0;
    int tests_failed = 0;

    i_cache_2way #(.DATA_WIDTH(32), .ADD_WIDTH(12), .INDEX_WIDTH(6)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .cpu_add(cpu_add),
        .cpu_data_in(cpu_data_in),
        .cpu_ren(cpu_ren),
        .cpu_wen(cpu_wen),
        .hit_miss(hit_miss),
        .cpu_data_out(cpu_data_out),
        .m_data_out(m_data_out),
        .m_wr_address(m_wr_address),
        .m_wen(m_wen),
        .m_rd_address(m_rd_address),
        .m_ren(m_ren),
        .m_data_in(m_data_in)
    );

    // 10 ns clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Attached memory: only written words are stored; all others read as preload 0x1000_0000|a
    logic [31:0] bmem [int];

    function automatic logic [31:0] bmem_read(input logic [11:0] a);
        if (bmem.exists(int'(a)))
            return bmem[int'(a)];
        return 32'h1000_0000 | {20'h0, a};
    endfunction

    // Memory ports: registered read when m_ren, write when m_wen, read sees the old contents
    always @(posedge clock) begin
        if (m_ren)
            m_data_in <= bmem_read(m_rd_address);
        if (m_wen)
            bmem[int'(m_wr_address)] = m_data_out;
    end

    // Reference model: per set an MRU-first list of blocks, plus the expected memory image
    typedef struct packed {
        logic        v;
        logic        d;
        logic [5:0]  t;
        logic [31:0] data;
    } ent_t;

    ent_t        ent [64][2];
    logic [31:0] gmem [int];

    function automatic logic [31:0] gmem_read(input logic [11:0] a);
        if (gmem.exists(int'(a)))
            return gmem[int'(a)];
        return 32'h1000_0000 | {20'h0, a};
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int k = 0; k < 2; k++)
                ent[s][k] = '0;
    endtask

    task automatic model_access(input logic [11:0] addr, input logic [31:0] wdata, input logic is_wr,
                                output bit e_hit, output bit e_wb, output logic [11:0] e_wb_addr,
                                output logic [31:0] e_wb_data, output logic [31:0] e_rdata);
        int          s;
        int          k;
        logic [5:0]  t;
        ent_t        tmp;
        s = int'(addr[5:0]);
        t = addr[11:6];
        k = -1;
        e_wb      = 1'b0;
        e_wb_addr = '0;
        e_wb_data = '0;
        for (int i = 0; i < 2; i++)
            if (ent[s][i].v && ent[s][i].t == t)
                k = i;
        if (k >= 0) begin
            e_hit   = 1'b1;
            e_rdata = ent[s][k].data;
            if (is_wr) begin
                ent[s][k].data = wdata;
                ent[s][k].d    = 1'b1;
            end
            if (k == 1) begin
                tmp       = ent[s][0];
                ent[s][0] = ent[s][1];
                ent[s][1] = tmp;
            end
        end else begin
            e_hit   = 1'b0;
            e_rdata = gmem_read(addr);
            if (ent[s][0].v && ent[s][1].v && ent[s][1].d) begin
                e_wb      = 1'b1;
                e_wb_addr = {ent[s][1].t, addr[5:0]};
                e_wb_data = ent[s][1].data;
                gmem[int'(e_wb_addr)] = e_wb_data;
            end
            if (ent[s][0].v)
                ent[s][1] = ent[s][0];
            ent[s][0].v    = 1'b1;
            ent[s][0].d    = is_wr;
            ent[s][0].t    = t;
            ent[s][0].data = is_wr ? wdata : e_rdata;
        end
    endtask

    // One CPU transaction: hold the request for `hold` edges, then idle for one edge.
    // Every cycle is compared against the model.
    task automatic do_access(input string name, input logic [11:0] addr, input logic [31:0] wdata,
                             input logic ren, input logic wen, input int hold);
        bit          e_hit, e_wb;
        logic [11:0] e_wb_addr;
        logic [31:0] e_wb_data, e_rdata;
        model_access(addr, wdata, wen, e_hit, e_wb, e_wb_addr, e_wb_data, e_rdata);
        @(negedge clock);
        cpu_add = addr; cpu_data_in = wdata; cpu_ren = ren; cpu_wen = wen;
        @(posedge clock); #1;
        tests_run++;
        if (hit_miss !== e_hit) begin
            tests_failed++;
            $display("[TB] FAIL %s hit_miss @%h: got %b expected %b", name, addr, hit_miss, e_hit);
        end
        if (e_hit) begin
            tests_run++;
            if ({m_ren, m_wen} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL %s strobes on hit: got ren=%b wen=%b expected 0 0", name, m_ren, m_wen);
            end
            if (!wen) begin
                tests_run++;
                if (cpu_data_out !== e_rdata) begin
                    tests_failed++;
                    $display("[TB] FAIL %s hit data @%h: got %h expected %h", name, addr, cpu_data_out, e_rdata);
                end
            end
        end else begin
            tests_run++;
            if (m_ren !== 1'b1 || m_rd_address !== addr) begin
                tests_failed++;
                $display("[TB] FAIL %s fill request: got ren=%b addr=%h expected ren=1 addr=%h",
                         name, m_ren, m_rd_address, addr);
            end
            tests_run++;
            if (m_wen !== e_wb) begin
                tests_failed++;
                $display("[TB] FAIL %s writeback strobe: got %b expected %b", name, m_wen, e_wb);
            end
            if (e_wb) begin
                tests_run++;
                if (m_wr_address !== e_wb_addr || m_data_out !== e_wb_data) begin
                    tests_failed++;
                    $display("[TB] FAIL %s writeback: got %h=%h expected %h=%h",
                             name, m_wr_address, m_data_out, e_wb_addr, e_wb_data);
                end
            end
        end
        @(posedge clock); #1;
        if (!e_hit) begin
            tests_run++;
            if ({m_ren, m_wen} !== 2'b00) begin
                tests_failed++;
                $display("[TB] FAIL %s strobe width: got ren=%b wen=%b expected 0 0", name, m_ren, m_wen);
            end
        end
        @(posedge clock); #1;
        tests_run++;
        if (hit_miss !== e_hit) begin
            tests_failed++;
            $display("[TB] FAIL %s hit_miss third edge: got %b expected %b", name, hit_miss, e_hit);
        end
        if (!e_hit && !wen) begin
            tests_run++;
            if (cpu_data_out !== e_rdata) begin
                tests_failed++;
                $display("[TB] FAIL %s fill data @%h: got %h expected %h", name, addr, cpu_data_out, e_rdata);
            end
        end
        if (hold > 3) begin
            @(posedge clock); #1;
            tests_run++;
            if (hit_miss !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL %s held repeat: got hit_miss=%b expected 1", name, hit_miss);
            end
        end
        @(negedge clock);
        cpu_ren = 1'b0; cpu_wen = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (hit_miss !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL %s idle hit_miss: got %b expected 0", name, hit_miss);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        tests_run++;
        if ({hit_miss, m_ren, m_wen} !== 3'b000 || cpu_data_out !== 32'h0 || m_data_out !== 32'h0 ||
            m_wr_address !== 12'h0 || m_rd_address !== 12'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset outputs: got hit=%b ren=%b wen=%b dout=%h mdo=%h wa=%h ra=%h expected all 0",
                     hit_miss, m_ren, m_wen, cpu_data_out, m_data_out, m_wr_address, m_rd_address);
        end
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_read_miss();
        do_access("read_miss", 12'hABC, 32'h0, 1'b1, 1'b0, 4);
        tests_run++;
        if (cpu_data_out !== 32'h1000_0ABC) begin
            tests_failed++;
            $display("[TB] FAIL read_miss value: got %h expected 10000abc", cpu_data_out);
        end
    endtask

    task automatic test_write_hit();
        do_access("write_hit", 12'hABC, 32'hBADD_BEEF, 1'b0, 1'b1, 3);
        do_access("read_after_write", 12'hABC, 32'h0, 1'b1, 1'b0, 3);
        tests_run++;
        if (cpu_data_out !== 32'hBADD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL write_hit readback: got %h expected baddbeef", cpu_data_out);
        end
    endtask

    task automatic test_eviction();
        do_access("fill_way2", 12'h1BC, 32'h0, 1'b1, 1'b0, 3);
        do_access("evict_dirty", 12'h2FC, 32'h0, 1'b1, 1'b0, 3);
        tests_run++;
        if (bmem_read(12'hABC) !== 32'hBADD_BEEF) begin
            tests_failed++;
            $display("[TB] FAIL evict memory[abc]: got %h expected baddbeef", bmem_read(12'hABC));
        end
        do_access("reread_evicted", 12'hABC, 32'h0, 1'b1, 1'b0, 3);
        do_access("lru_victim_gone", 12'h1BC, 32'h0, 1'b1, 1'b0, 3);
    endtask

    task automatic test_write_miss();
        do_access("write_miss", 12'h004, 32'h1234_5678, 1'b0, 1'b1, 3);
        do_access("read_write_alloc", 12'h004, 32'h0, 1'b1, 1'b0, 3);
        tests_run++;
        if (bmem_read(12'h004) !== 32'h1000_0004) begin
            tests_failed++;
            $display("[TB] FAIL write_miss memory[004]: got %h expected 10000004", bmem_read(12'h004));
        end
    endtask

    task automatic test_read_write_both();
        do_access("ren_wen_both", 12'h010, 32'hAAAA_AAAA, 1'b1, 1'b1, 3);
        do_access("read_both", 12'h010, 32'h0, 1'b1, 1'b0, 3);
        tests_run++;
        if (cpu_data_out !== 32'hAAAA_AAAA) begin
            tests_failed++;
            $display("[TB] FAIL both readback: got %h expected aaaaaaaa", cpu_data_out);
        end
    endtask

    task automatic test_reset_mid_miss();
        bit          e_hit, e_wb;
        logic [11:0] e_wb_addr;
        logic [31:0] e_wb_data, e_rdata;
        model_access(12'h040, 32'h0, 1'b0, e_hit, e_wb, e_wb_addr, e_wb_data, e_rdata);
        @(negedge clock);
        cpu_add = 12'h040; cpu_data_in = 32'h0; cpu_ren = 1'b1; cpu_wen = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if (m_ren !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_miss issue: got m_ren=%b expected 1", m_ren);
        end
        @(negedge clock);
        reset_n = 1'b0;
        @(posedge clock); #1;
        tests_run++;
        if ({m_ren, m_wen, hit_miss} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL mid_miss reset: got ren=%b wen=%b hit=%b expected 0 0 0", m_ren, m_wen, hit_miss);
        end
        @(negedge clock);
        reset_n = 1'b1; cpu_ren = 1'b0;
        model_reset();
        @(posedge clock); #1;
        do_access("after_reset", 12'h004, 32'h0, 1'b1, 1'b0, 3);
        tests_run++;
        if (cpu_data_out !== 32'h1000_0004) begin
            tests_failed++;
            $display("[TB] FAIL after_reset value: got %h expected 10000004", cpu_data_out);
        end
    endtask

    task automatic test_random();
        logic [11:0] addr;
        logic [31:0] data;
        int          op;
        for (int i = 0; i < 200; i++) begin
            addr = {3'b000, 3'($urandom_range(0, 7)), 4'b0000, 2'($urandom_range(0, 3))};
            data = $urandom;
            op   = $urandom_range(0, 2);
            do_access("random", addr, data, op != 1, op != 0, 3);
        end
    endtask

    task automatic test_memory_image();
        int diffs = 0;
        for (int a = 0; a < 4096; a++)
            if (bmem_read(12'(a)) !== gmem_read(12'(a)))
                diffs++;
        tests_run++;
        if (diffs != 0) begin
            tests_failed++;
            $display("[TB] FAIL memory_image: got %0d differing words expected 0", diffs);
        end
    endtask

    // Watchdog so the run can never hang
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Test sequence
    initial begin
        reset_n = 1'b0; cpu_add = '0; cpu_data_in = '0; cpu_ren = 1'b0; cpu_wen = 1'b0;
        test_reset();
        test_read_miss();
        test_write_hit();
        test_eviction();
        test_write_miss();
        test_read_write_both();
        test_reset_mid_miss();
        test_random();
        test_memory_image();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
